// File: rtl/avmm_matrix_mem_if.sv
// Avalon-MM command/response bundle for the matrix memory slave.
// The master drives commands and write data; the slave returns
// waitrequest and the pipelined read response.
interface avmm_matrix_mem_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    logic [1:0]          response;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid, response
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid, response
    );
endinterface

// File: rtl/avmm_matrix_mem.sv
// Avalon-MM slave holding a DEPTH x DATA_W matrix memory.
// Writes are posted and byte-enabled. Reads are snapshotted at the
// accept edge into a small in-order FIFO; a valid shift line of length
// RD_DELAY+1 times each response, so latency is fixed and independent
// of later writes. At most MAX_PEND reads may be outstanding.
module avmm_matrix_mem #(
    parameter int    DATA_W    = 64,
    parameter int    DEPTH     = 8,
    parameter int    ADDR_W    = 32,
    parameter int    RD_DELAY  = 10,
    parameter int    MAX_PEND  = 4,
    parameter string INIT_FILE = ""
) (
    input  logic               clk,
    input  logic               reset,
    avmm_matrix_mem_if.slave   bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int LAT   = RD_DELAY + 1;
    localparam int PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
    localparam int CNT_W = $clog2(MAX_PEND + 1);

    logic [DATA_W-1:0] mem [DEPTH];

    // Response FIFO: holds snapshotted data until its valid slot comes due
    logic [DATA_W-1:0] fifo_data [MAX_PEND];
    logic              fifo_err  [MAX_PEND];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic [CNT_W-1:0]  pend_cnt;
    logic [LAT-1:0]    vld_sr;

    logic              wreq;
    logic              in_range_p0;
    logic [IDX_W-1:0]  idx_p0;
    logic              wr_acc_p0;
    logic              rd_acc_p0;
    logic [DATA_W-1:0] rd_word_p0;
    logic              rsp_due;

    // Circular pointer advance; MAX_PEND need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_PEND - 1))
            return '0;
        return p + PTR_W'(1);
    endfunction

    // Stage p0: command decode and acceptance
    assign wreq        = reset | (pend_cnt == CNT_W'(MAX_PEND));
    assign in_range_p0 = (bus.address < ADDR_W'(DEPTH));
    assign idx_p0      = bus.address[IDX_W-1:0];
    // read+write together is resolved as a write; the read is dropped
    assign wr_acc_p0   = bus.write & ~wreq;
    assign rd_acc_p0   = bus.read & ~bus.write & ~wreq;
    assign rd_word_p0  = in_range_p0 ? mem[idx_p0] : '0;

    assign bus.waitrequest = wreq;

    // Stage LAT: the oldest outstanding read returns
    assign rsp_due = vld_sr[LAT-1];

    // Byte-enabled posted write; out-of-range writes are dropped
    always_ff @(posedge clk) begin
        if (wr_acc_p0 && in_range_p0) begin
            for (int b = 0; b < BE_W; b++) begin
                if (bus.byteenable[b])
                    mem[idx_p0][8*b +: 8] <= bus.writedata[8*b +: 8];
            end
        end
    end

    // Capture the read snapshot at the accept edge so later writes cannot leak in
    always_ff @(posedge clk) begin
        if (rd_acc_p0) begin
            fifo_data[wr_ptr] <= rd_word_p0;
            fifo_err[wr_ptr]  <= ~in_range_p0;
        end
    end

    // FIFO pointers, outstanding count and latency line; reset discards in-flight reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pend_cnt <= '0;
            vld_sr   <= '0;
        end else begin
            vld_sr <= (vld_sr << 1) | LAT'(rd_acc_p0);
            if (rd_acc_p0)
                wr_ptr <= ptr_next(wr_ptr);
            if (rsp_due)
                rd_ptr <= ptr_next(rd_ptr);
            case ({rd_acc_p0, rsp_due})
                2'b10:   pend_cnt <= pend_cnt + CNT_W'(1);
                2'b01:   pend_cnt <= pend_cnt - CNT_W'(1);
                default: pend_cnt <= pend_cnt;
            endcase
        end
    end

    // Registered response; data and status hold their last value while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.readdatavalid <= 1'b0;
            bus.readdata      <= '0;
            bus.response      <= 2'b00;
        end else begin
            bus.readdatavalid <= rsp_due;
            if (rsp_due) begin
                bus.readdata <= fifo_data[rd_ptr];
                bus.response <= fifo_err[rd_ptr] ? 2'b10 : 2'b00;
            end
        end
    end
endmodule

// File: tb/tb_avmm_matrix_mem.sv
// Directed bench for avmm_matrix_mem. Commands are issued by the main
// process, which pushes the expected response (data, status, arrival
// cycle) into a queue; an independent monitor pops and compares on
// every readdatavalid.
module tb_avmm_matrix_mem;
    localparam int DW  = 64;
    localparam int AW  = 32;
    localparam int LAT = 11;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    avmm_matrix_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    avmm_matrix_mem #(
        .DATA_W(DW), .DEPTH(8), .ADDR_W(AW),
        .RD_DELAY(10), .MAX_PEND(4), .INIT_FILE("")
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s", name);
    endtask

    // Response monitor
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.readdatavalid) begin
            if (sbq.size() == 0) begin
                fail_now("spurious_readdatavalid");
            end else begin
                e = sbq.pop_front();
                check("rd_data", bus.readdata, e.data);
                check("rd_resp", 64'(bus.response), 64'(e.resp));
                check("rd_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Issue one command from a negedge; returns the accept edge index
    task automatic cmd(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [63:0] wd, input logic [7:0] be,
                       input logic [63:0] ed, input logic [1:0] er, output int acc);
        bit ok;
        int waited;
        bus.read = rd; bus.write = wr; bus.address = a;
        bus.writedata = wd; bus.byteenable = be;
        acc = -1;
        waited = 0;
        while (acc < 0 && waited < 100) begin
            ok = !bus.waitrequest;
            @(negedge clk);
            if (ok) acc = cyc;
            waited++;
        end
        if (acc < 0) fail_now("cmd_accept_timeout");
        else if (rd && !wr) sbq.push_back('{ed, er, acc + LAT});
        bus.read = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic wr_cmd(input logic [31:0] a, input logic [63:0] d, input logic [7:0] be, output int acc);
        cmd(1'b0, 1'b1, a, d, be, 64'h0, 2'b00, acc);
    endtask

    task automatic rd_cmd(input logic [31:0] a, input logic [63:0] ed, input logic [1:0] er, output int acc);
        cmd(1'b1, 1'b0, a, 64'h0, 8'h00, ed, er, acc);
    endtask

    task automatic drain();
        int w = 0;
        while (sbq.size() != 0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (sbq.size() != 0) fail_now("drain_timeout");
        @(negedge clk);
    endtask

    function automatic logic [63:0] base_row(input int i);
        return 64'hA0A0_0000_0000_0000 | 64'(i);
    endfunction

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int acc2;
        int accs[8];
        logic [63:0] row [8];

        bus.read = 1'b0; bus.write = 1'b0; bus.address = '0;
        bus.writedata = '0; bus.byteenable = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_waitrequest", 64'(bus.waitrequest), 64'd1);
        check("reset_readdatavalid", 64'(bus.readdatavalid), 64'd0);
        check("reset_readdata", bus.readdata, 64'h0);
        check("reset_response", 64'(bus.response), 64'd0);
        reset = 1'b0;
        #1;
        check("waitrequest_after_reset", 64'(bus.waitrequest), 64'd0);

        // Known contents for every row
        for (int i = 0; i < 8; i++) begin
            row[i] = base_row(i);
            wr_cmd(32'(i), row[i], 8'hFF, acc);
        end

        // T1: full write then read
        wr_cmd(32'd3, 64'h0123_4567_89AB_CDEF, 8'hFF, acc);
        row[3] = 64'h0123_4567_89AB_CDEF;
        rd_cmd(32'd3, 64'h0123_4567_89AB_CDEF, 2'b00, acc);
        drain();

        // T2: partial write, low four bytes only
        wr_cmd(32'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, acc);
        row[3] = 64'h0123_4567_FFFF_FFFF;
        rd_cmd(32'd3, 64'h0123_4567_FFFF_FFFF, 2'b00, acc);
        drain();

        // T3: back-to-back reads against MAX_PEND=4
        for (int i = 0; i < 8; i++) begin
            rd_cmd(32'(i), row[i], 2'b00, accs[i]);
            if (i == 3) check("waitrequest_after_4th", 64'(bus.waitrequest), 64'd1);
        end
        check("t3_accept_2nd", 64'(accs[1] - accs[0]), 64'd1);
        check("t3_accept_4th", 64'(accs[3] - accs[0]), 64'd3);
        check("t3_accept_5th_stall", 64'(accs[4] - accs[0]), 64'd12);
        check("t3_accept_8th", 64'(accs[7] - accs[0]), 64'd15);
        drain();

        // T4: read-then-write hazard on row 2
        rd_cmd(32'd2, 64'hA0A0_0000_0000_0002, 2'b00, acc);
        wr_cmd(32'd2, 64'h0000_0000_0000_DEAD, 8'hFF, acc2);
        row[2] = 64'h0000_0000_0000_DEAD;
        check("t4_write_next_cycle", 64'(acc2 - acc), 64'd1);
        rd_cmd(32'd2, 64'h0000_0000_0000_DEAD, 2'b00, acc);
        drain();

        // T5: out-of-range read and write
        rd_cmd(32'd8, 64'h0, 2'b10, acc);
        wr_cmd(32'd9, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, acc);
        for (int i = 0; i < 8; i++) rd_cmd(32'(i), row[i], 2'b00, acc);
        drain();
        check("idle_hold_readdata", bus.readdata, 64'hA0A0_0000_0000_0007);
        check("idle_readdatavalid", 64'(bus.readdatavalid), 64'd0);

        // T6: reset with three reads in flight
        rd_cmd(32'd4, row[4], 2'b00, acc);
        rd_cmd(32'd5, row[5], 2'b00, acc);
        rd_cmd(32'd6, row[6], 2'b00, acc);
        reset = 1'b1;
        #1;
        check("midreset_waitrequest", 64'(bus.waitrequest), 64'd1);
        check("midreset_readdatavalid", 64'(bus.readdatavalid), 64'd0);
        check("midreset_readdata", bus.readdata, 64'h0);
        sbq.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) rd_cmd(32'(i), row[i], 2'b00, accs[i]);
        check("t6_no_stall", 64'(accs[3] - accs[0]), 64'd3);
        drain();
        repeat (15) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
